// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 640x480 VGA controller: timing constants,
// counter width, the 4:4:4 pixel type and the pipeline stage records.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 2 * CNT_W;

    // Horizontal timing, in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800
    localparam int H_SYNC_START = H_ACTIVE + H_FP;              // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;    // 751

    // Vertical timing, in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525
    localparam int V_SYNC_START = V_ACTIVE + V_FP;              // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;    // 491

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    // Sync/blank bundle carried down the pipeline (sync bits active low)
    typedef struct packed {
        logic hs;
        logic vs;
        logic hblank;
        logic vblank;
    } sync_t;

    typedef struct packed {
        logic  active;
        sync_t sync;
    } stage_t;

    localparam sync_t  SYNC_IDLE  = '{hs: 1'b1, vs: 1'b1, hblank: 1'b1, vblank: 1'b1};
    localparam stage_t STAGE_IDLE = '{active: 1'b0, sync: SYNC_IDLE};

endpackage

// File: rtl/vga_if.sv
// -----------------------------------------------------------------------------
// vga_if
// VRAM read bus. The controller (master) drives addr; the VRAM (slave)
// returns the 12-bit pixel on data one clock later.
//   addr : {line[9:0], column[9:0]}
//   data : pixel_t, R in [11:8], G in [7:4], B in [3:0]
// -----------------------------------------------------------------------------
interface vga_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] addr;
    pixel_t            data;

    modport master (output addr, input  data);
    modport slave  (input  addr, output data);

endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Horizontal/vertical position counters plus the stage-0 decode of the
// current position.
// Ports:
//   clk, rst      : pixel clock, synchronous active-high reset
//   module_en     : counters are held at (0,0) while low
//   hcnt, vcnt    : current column / line
//   active        : position is inside the visible area
//   hs0, vs0      : undelayed sync, active low
//   hblank,vblank : undelayed blank flags
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     module_en,
    output logic [vga_pkg::CNT_W-1:0] hcnt,
    output logic [vga_pkg::CNT_W-1:0] vcnt,
    output logic                     active,
    output logic                     hs0,
    output logic                     vs0,
    output logic                     hblank,
    output logic                     vblank
);
    import vga_pkg::*;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = cnt_t'(LINE_LEN - 1);
    localparam cnt_t V_LAST   = cnt_t'(FRAME_LINES - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Disable behaves like reset so that re-enabling always starts a new
    // frame at (0,0) instead of resuming a partial line.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || !module_en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + cnt_t'(1);
        end else begin
            hcnt <= hcnt + cnt_t'(1);
        end
    end

    assign hblank = (hcnt >= H_VIS);
    assign vblank = (vcnt >= V_VIS);
    assign active = !hblank && !vblank;
    assign hs0    = !((hcnt >= HS_START) && (hcnt <= HS_END));
    assign vs0    = !((vcnt >= VS_START) && (vcnt <= VS_END));

endmodule

// File: rtl/vga_controller.sv
// -----------------------------------------------------------------------------
// vga_controller
// 640x480 VGA controller: timing generation, VRAM addressing and a 2-stage
// output pipeline that lines the 1-cycle VRAM read up with sync/blank.
// Ports:
//   clk, rst       : pixel clock, synchronous active-high reset
//   module_en      : enable; low forces all outputs idle and counters to 0
//   vram           : VRAM read bus (addr out, data in one clock later)
//   hbrank, vbrank : blanking status, 1 outside active columns / lines
//   hsync, vsync   : sync outputs, active low
//   rdata/gdata/bdata : 4-bit colour outputs, 0 during blanking
// All outputs lag the counter position that produced them by 2 clocks.
// -----------------------------------------------------------------------------
module vga_controller #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        module_en,
    vga_if.master       vram,
    output logic        hbrank,
    output logic        vbrank,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  rdata,
    output logic [3:0]  gdata,
    output logic [3:0]  bdata
);
    import vga_pkg::*;

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             active, hs0, vs0, hblank, vblank;

    stage_t s0, s1;
    sync_t  s2;
    pixel_t pix;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .module_en (module_en),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .active    (active),
        .hs0       (hs0),
        .vs0       (vs0),
        .hblank    (hblank),
        .vblank    (vblank)
    );

    // Address is driven straight from the counters, blanking included;
    // whatever VRAM returns there is masked off by the stage-1 active bit.
    assign vram.addr = {vcnt, hcnt};

    assign s0 = '{active: active,
                  sync:   '{hs: hs0, vs: vs0, hblank: hblank, vblank: vblank}};

    // Stage 1 waits for the VRAM read; stage 2 joins the returned pixel
    // with the sync/blank state of the same position.
    // NOTE: pipeline registers are reset (not left free-running) so the
    // outputs are idle on the very next clock after rst or disable.
    always_ff @(posedge clk) begin
        if (rst || !module_en) begin
            s1  <= STAGE_IDLE;
            s2  <= SYNC_IDLE;
            pix <= pixel_t'('0);
        end else begin
            s1  <= s0;
            s2  <= s1.sync;
            pix <= s1.active ? vram.data : pixel_t'('0);
        end
    end

    assign hsync  = s2.hs;
    assign vsync  = s2.vs;
    assign hbrank = s2.hblank;
    assign vbrank = s2.vblank;
    assign rdata  = pix.r;
    assign gdata  = pix.g;
    assign bdata  = pix.b;

endmodule

// File: tb/tb_vga_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_controller
// dut_a runs the full 640x480 timing for reset, line timing, pixel data,
// enable-drop and mid-frame reset. dut_b runs a scaled-down timing so two
// complete frames of vertical timing fit in a short run.
// -----------------------------------------------------------------------------
module tb_vga_controller;
    import vga_pkg::*;

    // Full timing, written out independently of the package
    localparam int HA = 640, HFP = 16, HS = 96, HT = 800;
    localparam int VA = 480, VFP = 10, VS = 2,  VT = 525;

    // Scaled timing for dut_b
    localparam int BHA = 32, BHFP = 4, BHS = 8, BHBP = 4, BHT = 48;
    localparam int BVA = 8,  BVFP = 2, BVS = 2, BVBP = 3, BVT = 15;
    localparam int BFRAME = BHT * BVT;   // 720

    logic clk = 1'b0;
    logic rst, en_a, en_b;
    always #21 clk = ~clk;

    vga_if vram_a ();
    vga_if vram_b ();

    logic       hb_a, vb_a, hs_a, vs_a;
    logic [3:0] r_a, g_a, b_a;
    logic       hb_b, vb_b, hs_b, vs_b;
    logic [3:0] r_b, g_b, b_b;
    logic [11:0] rgb_a, rgb_b;
    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_b = {r_b, g_b, b_b};

    vga_controller dut_a (
        .clk (clk), .rst (rst), .module_en (en_a), .vram (vram_a),
        .hbrank (hb_a), .vbrank (vb_a), .hsync (hs_a), .vsync (vs_a),
        .rdata (r_a), .gdata (g_a), .bdata (b_a)
    );

    vga_controller #(
        .H_ACTIVE (BHA), .H_FP (BHFP), .H_SYNC (BHS), .H_BP (BHBP),
        .V_ACTIVE (BVA), .V_FP (BVFP), .V_SYNC (BVS), .V_BP (BVBP)
    ) dut_b (
        .clk (clk), .rst (rst), .module_en (en_b), .vram (vram_b),
        .hbrank (hb_b), .vbrank (vb_b), .hsync (hs_b), .vsync (vs_b),
        .rdata (r_b), .gdata (g_b), .bdata (b_b)
    );

    // VRAM models: pixel = low 12 address bits, one clock after the address
    always @(posedge clk) vram_a.data <= pixel_t'(vram_a.addr[11:0]);
    always @(posedge clk) vram_b.data <= pixel_t'(vram_b.addr[11:0]);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard for dut_a ----------------
    typedef struct {
        bit         idle;
        int         x;
        int         y;
        logic [11:0] rgb;
        logic       hs, vs, hb, vb;
    } exp_t;

    exp_t q[$];
    int   mx = 0, my = 0;   // counter position the DUT should hold now

    function automatic exp_t idle_exp();
        exp_t e;
        e.idle = 1'b1; e.x = -1; e.y = -1;
        e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.hb = 1'b1; e.vb = 1'b1;
        return e;
    endfunction

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int   a;
        e.idle = 1'b0; e.x = x; e.y = y;
        e.hb  = (x >= HA);
        e.vb  = (y >= VA);
        e.hs  = !((x >= HA + HFP) && (x < HA + HFP + HS));
        e.vs  = !((y >= VA + VFP) && (y < VA + VFP + VS));
        a     = y * 1024 + x;
        e.rgb = (!e.hb && !e.vb) ? a[11:0] : 12'h000;
        return e;
    endfunction

    // Hand-computed output at specific pixel positions of dut_a
    typedef struct {
        string      name;
        int         x;
        int         y;
        logic [15:0] out;   // {rgb, hsync, vsync, hbrank, vbrank}
    } vec_t;
    localparam int NT = 12;
    vec_t tbl[NT];

    function automatic logic [15:0] outs_a();
        return {rgb_a, hs_a, vs_a, hb_a, vb_a};
    endfunction

    // One clock of dut_a: drive inputs, push expectation, sample at negedge
    task automatic step_a(input bit r, input bit en);
        exp_t e;
        logic [15:0] act;
        rst  = r;
        en_a = en;
        if (r || !en) begin
            q.delete();
            q.push_back(idle_exp());
            q.push_back(idle_exp());
            mx = 0; my = 0;
        end else begin
            q.push_back(model(mx, my));
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        e   = q.pop_front();
        act = outs_a();
        check("sb_out", 32'(act), 32'({e.rgb, e.hs, e.vs, e.hb, e.vb}));
        check("sb_addr", 32'(vram_a.addr), 32'(my * 1024 + mx));
        if (!e.idle)
            for (int i = 0; i < NT; i++)
                if (tbl[i].x == e.x && tbl[i].y == e.y)
                    check(tbl[i].name, 32'(act), 32'(tbl[i].out));
    endtask

    initial begin
        int hs_low, hs_first, hb_high, rgb_blank;
        int vs_low[2], vs_first[2], vb_high[2], hbb_high[2], rgbb_blank[2];
        int fall[2], nfall;
        logic prev_vs;

        tbl[0]  = '{"px_0_0",     0, 0, {12'h000, 4'b1100}};
        tbl[1]  = '{"px_5_0",     5, 0, {12'h005, 4'b1100}};
        tbl[2]  = '{"px_639_0", 639, 0, {12'h27F, 4'b1100}};
        tbl[3]  = '{"px_640_0", 640, 0, {12'h000, 4'b1110}};
        tbl[4]  = '{"px_655_0", 655, 0, {12'h000, 4'b1110}};
        tbl[5]  = '{"px_656_0", 656, 0, {12'h000, 4'b0110}};
        tbl[6]  = '{"px_751_0", 751, 0, {12'h000, 4'b0110}};
        tbl[7]  = '{"px_752_0", 752, 0, {12'h000, 4'b1110}};
        tbl[8]  = '{"px_799_0", 799, 0, {12'h000, 4'b1110}};
        tbl[9]  = '{"px_0_1",     0, 1, {12'h400, 4'b1100}};
        tbl[10] = '{"px_100_1", 100, 1, {12'h464, 4'b1100}};
        tbl[11] = '{"px_3_2",     3, 2, {12'h803, 4'b1100}};

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;

        // Reset, then idle with reset released but not enabled
        for (int i = 0; i < 10; i++) step_a(1'b1, 1'b0);
        check("reset_outputs", 32'(outs_a()), 32'({12'h000, 4'b1111}));
        check("reset_addr", 32'(vram_a.addr), 32'd0);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0);

        // Enable; observation k shows column k-1 of line 0 for k=1..800
        hs_low = 0; hs_first = -1; hb_high = 0; rgb_blank = 0;
        for (int k = 0; k < 2 * HT + 10; k++) begin
            step_a(1'b0, 1'b1);
            if (k == 1) check("first_active", 32'(outs_a()), 32'({12'h000, 4'b1100}));
            if (k >= 1 && k <= HT) begin
                if (!hs_a) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = k - 1;
                end
                if (hb_a) hb_high++;
                if (hb_a && rgb_a != 12'h000) rgb_blank++;
            end
        end
        check("hsync_low_len", 32'(hs_low), 32'(HS));
        check("hsync_start", 32'(hs_first), 32'(HA + HFP));
        check("hbrank_len", 32'(hb_high), 32'(HT - HA));
        check("rgb_in_hblank", 32'(rgb_blank), 32'd0);

        // Drop enable at line 3, x=300, hold off 50 clocks, re-enable
        for (int k = 0; k < 4 * HT && !(mx == 300 && my == 3); k++) step_a(1'b0, 1'b1);
        check("drop_position", 32'(vram_a.addr), 32'(3 * 1024 + 300));
        step_a(1'b0, 1'b0);
        check("drop_idle", 32'(outs_a()), 32'({12'h000, 4'b1111}));
        check("drop_addr", 32'(vram_a.addr), 32'd0);
        for (int i = 0; i < 49; i++) step_a(1'b0, 1'b0);
        step_a(1'b0, 1'b1);
        check("reen_addr", 32'(vram_a.addr), 32'd1);
        step_a(1'b0, 1'b1);
        check("reen_first_px", 32'(outs_a()), 32'({12'h000, 4'b1100}));
        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b1);

        // Reset mid-frame with enable held high; reset wins
        for (int k = 0; k < 2 * HT && !(mx == 100 && my == 1); k++) step_a(1'b0, 1'b1);
        step_a(1'b1, 1'b1);
        check("rst_idle", 32'(outs_a()), 32'({12'h000, 4'b1111}));
        check("rst_addr", 32'(vram_a.addr), 32'd0);
        step_a(1'b0, 1'b1);
        step_a(1'b0, 1'b1);
        check("rst_restart_px", 32'(outs_a()), 32'({12'h000, 4'b1100}));
        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b1);

        // Two frames of scaled timing on dut_b
        rst = 1'b0; en_a = 1'b0; en_b = 1'b1;
        for (int f = 0; f < 2; f++) begin
            vs_low[f] = 0; vs_first[f] = -1; vb_high[f] = 0;
            hbb_high[f] = 0; rgbb_blank[f] = 0; fall[f] = -1;
        end
        nfall = 0; prev_vs = 1'b1;
        for (int k = 0; k < 2 * BFRAME + 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 1 && k <= 2 * BFRAME) begin
                int f, off;
                f   = (k - 1) / BFRAME;
                off = (k - 1) % BFRAME;
                if (!vs_b) begin
                    vs_low[f]++;
                    if (vs_first[f] < 0) vs_first[f] = off;
                end
                if (vb_b) vb_high[f]++;
                if (hb_b) hbb_high[f]++;
                if ((hb_b || vb_b) && rgb_b != 12'h000) rgbb_blank[f]++;
            end
            if (prev_vs && !vs_b && nfall < 2) begin
                fall[nfall] = k;
                nfall++;
            end
            prev_vs = vs_b;
        end
        for (int f = 0; f < 2; f++) begin
            check($sformatf("vsync_low_len_f%0d", f), 32'(vs_low[f]), 32'(BVS * BHT));
            check($sformatf("vsync_start_f%0d", f), 32'(vs_first[f]), 32'((BVA + BVFP) * BHT));
            check($sformatf("vbrank_len_f%0d", f), 32'(vb_high[f]), 32'((BVT - BVA) * BHT));
            check($sformatf("hbrank_len_f%0d", f), 32'(hbb_high[f]), 32'((BHT - BHA) * BVT));
            check($sformatf("rgb_in_blank_f%0d", f), 32'(rgbb_blank[f]), 32'd0);
        end
        check("frame_period", 32'(fall[1] - fall[0]), 32'(BFRAME));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
Name: vga_controller

Overview:
- 640x480 VGA display controller: generates horizontal and vertical timing, addresses an external VRAM, and drives 4:4:4 RGB plus the sync outputs.
- Sits between the VRAM (12-bit pixel per address, synchronous 1-cycle read) and the board VGA connector.
- Exports horizontal and vertical blanking status for the peripheral register block.
- Pixel clock is about 25 MHz. The bench runs at about 23.8 MHz; this is acceptable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (V_TOTAL = 525)

Ports:
- clk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- module_en  in  1  module enable from the register block
- hbrank  out  1  horizontal blanking status, 1 outside the active columns
- vbrank  out  1  vertical blanking status, 1 outside the active lines
- addr  out  20  VRAM read address = {vcnt[9:0], hcnt[9:0]}
- data  in  12  VRAM pixel read data, valid one clock after addr: [11:8]=R, [7:4]=G, [3:0]=B
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- rdata  out  4  red pixel
- gdata  out  4  green pixel
- bdata  out  4  blue pixel

Behaviour:
- Counters:
  - hcnt runs 0..799 and wraps to 0; at each wrap vcnt increments.
  - vcnt runs 0..524 and wraps to 0 when hcnt=799 and vcnt=524.
- Stage-0 decode from the counters:
  - active = (hcnt<640) && (vcnt<480)
  - hs0 = 0 while 656<=hcnt<=751
  - vs0 = 0 while 490<=vcnt<=491
- addr is combinational from the counters: addr = {vcnt, hcnt}. It is driven during blanking too; VRAM content there is ignored.
- Pipeline:
  - Stage 1 registers active, hs0, vs0, and the blank flags.
  - Stage 2 registers the stage-1 sync/blank values onto hsync/vsync/hbrank/vbrank. In the same cycle it registers the RGB outputs: {rdata,gdata,bdata} = stage-1 active ? data : 12'h000.
  - Every output is therefore 2 clocks behind the counter value that produced it.
  - Pixel (x,y) appears on RGB exactly 2 clocks after addr={y,x}, aligned with its own sync/blank.
- Blank flags: hbrank = (hcnt>=640), vbrank = (vcnt>=480), both delayed 2 clocks.
- Reset (rst=1), and every clock with module_en=0:
  - hcnt=vcnt=0, pipeline flushed
  - hsync=1, vsync=1, rgb=0, hbrank=1, vbrank=1
  - addr = 0
- Enable rising: the counters start from 0 on the first enabled clock. Active video therefore begins 2 clocks after module_en is sampled high, starting with pixel (0,0).
- Enable dropped mid-frame: outputs go idle on the next clock, with no partial-line completion. Re-enable restarts at a frame boundary (0,0).
- Simultaneous rst and module_en: reset wins.
- Frame period: 420000 clocks. Line period: 800 clocks.

Decomposition:
- Shared package vga_pkg holds:
  - timing localparams (H_*/V_* and derived H_TOTAL, V_TOTAL, sync start/end)
  - a pixel typedef (12-bit struct r/g/b)
  - counter width constant (10)
- One natural sub-module, vga_timing_gen: hcnt/vcnt counters plus stage-0 decode (active, hs0, vs0, blank flags).
- The top-level vga_controller adds the address mapping, the 2-stage pipeline and RGB gating.

Test Plan:
- Reset with module_en=0 for 10 clocks -> hsync=vsync=1, rgb=0, hbrank=vbrank=1, addr=0 throughout.
- Bench VRAM model returns data=addr[11:0] one clock after addr. Enable -> first active output 2 clocks later has rgb=12'h000. At x=5,y=0: rgb=12'h005. At x=0,y=1: rgb = (1<<10)[11:0] = 12'h400.
- Count clocks over one line -> hsync low for exactly 96 clocks, starting 656 clocks after that line's first active pixel. hbrank high for 160 clocks per 800-clock line. RGB is 0 whenever hbrank=1.
- Run 2 full frames (840000 clocks) -> vsync low for exactly 2 lines (1600 clocks) per frame, starting at line 490. vbrank high for 45 lines. Frame period is 420000 clocks.
- Drop module_en at line 100, x=300, then re-enable 50 clocks later -> outputs idle from the next clock. After re-enable, addr restarts at 0 and the first active pixel again appears 2 clocks after enable.
- Assert rst while module_en=1 mid-frame -> next clock: counters 0, all outputs at reset values. Deassert -> timing restarts from (0,0).
